// File: rtl/bram_port_arbiter.sv
`timescale 1ns/1ps
// Round-robin sharing of one single-port BRAM between port A (host bridge) and port B (user logic),
// with a tagged fixed-latency read-return pipe. Optional grant counters: BRAM_ARB_PERF_EN.
module bram_port_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 64,
  parameter int RD_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_a_req,
  input  logic            i_b_req,
  output logic            o_a_gnt,
  output logic            o_b_gnt,
  input  logic [DW/8-1:0] i_a_we,
  input  logic [DW/8-1:0] i_b_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_a_wdata,
  input  logic [DW-1:0]   i_b_wdata,
  output logic            o_a_rvalid,
  output logic            o_b_rvalid,
  output logic [DW-1:0]   o_a_rdata,
  output logic [DW-1:0]   o_b_rdata,
  output logic            o_bram_en,
  output logic [DW/8-1:0] o_bram_we,
  output logic [AW-1:0]   o_bram_addr,
  output logic [DW-1:0]   o_bram_wdata,
  input  logic [DW-1:0]   i_bram_rdata,
  output logic [31:0]     o_a_cnt,
  output logic [31:0]     o_b_cnt
);
  localparam int BW = DW / 8;

  logic            last_reg;  // 1 = B was granted last
  logic            a_gnt;
  logic            b_gnt;
  logic            any_gnt;
  logic            acc_read;
  logic [BW-1:0]   sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  logic            en_reg;
  logic [BW-1:0]   we_reg;
  logic [AW-1:0]   addr_reg;
  logic [DW-1:0]   wdata_reg;

  logic [RD_LAT:0] vld_reg;
  logic [RD_LAT:0] prt_reg;
  logic            a_rvalid_reg;
  logic            b_rvalid_reg;
  logic [DW-1:0]   a_rdata_reg;
  logic [DW-1:0]   b_rdata_reg;

  // On a tie the port that was not granted last wins.
  always_comb begin
    a_gnt     = i_a_req & (~i_b_req | last_reg);
    b_gnt     = i_b_req & (~i_a_req | ~last_reg);
    any_gnt   = a_gnt | b_gnt;
    sel_we    = b_gnt ? i_b_we    : i_a_we;
    sel_addr  = b_gnt ? i_b_addr  : i_a_addr;
    sel_wdata = b_gnt ? i_b_wdata : i_a_wdata;
    acc_read  = any_gnt & (sel_we == '0);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      last_reg  <= 1'b1;
      en_reg    <= 1'b0;
      we_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      en_reg <= any_gnt;
      if (any_gnt) begin
        last_reg  <= b_gnt;
        we_reg    <= sel_we;
        addr_reg  <= sel_addr;
        wdata_reg <= sel_wdata;
      end else begin
        we_reg <= '0;
      end
    end
  end

  // Tag stage k lines up with the command at stage 0 and with BRAM data at stage RD_LAT.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_reg      <= '0;
      prt_reg      <= '0;
      a_rvalid_reg <= 1'b0;
      b_rvalid_reg <= 1'b0;
      a_rdata_reg  <= '0;
      b_rdata_reg  <= '0;
    end else begin
      vld_reg      <= {vld_reg[RD_LAT-1:0], acc_read};
      prt_reg      <= {prt_reg[RD_LAT-1:0], b_gnt};
      a_rvalid_reg <= vld_reg[RD_LAT] & ~prt_reg[RD_LAT];
      b_rvalid_reg <= vld_reg[RD_LAT] &  prt_reg[RD_LAT];
      if (vld_reg[RD_LAT] && !prt_reg[RD_LAT]) a_rdata_reg <= i_bram_rdata;
      if (vld_reg[RD_LAT] &&  prt_reg[RD_LAT]) b_rdata_reg <= i_bram_rdata;
    end
  end

`ifdef BRAM_ARB_PERF_EN
  logic [31:0] a_cnt_reg;
  logic [31:0] b_cnt_reg;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      a_cnt_reg <= '0;
      b_cnt_reg <= '0;
    end else begin
      if (a_gnt && a_cnt_reg != 32'hFFFF_FFFF) a_cnt_reg <= a_cnt_reg + 32'd1;
      if (b_gnt && b_cnt_reg != 32'hFFFF_FFFF) b_cnt_reg <= b_cnt_reg + 32'd1;
    end
  end

  assign o_a_cnt = a_cnt_reg;
  assign o_b_cnt = b_cnt_reg;
`else
  assign o_a_cnt = '0;
  assign o_b_cnt = '0;
`endif

  assign o_a_gnt      = a_gnt;
  assign o_b_gnt      = b_gnt;
  assign o_bram_en    = en_reg;
  assign o_bram_we    = we_reg;
  assign o_bram_addr  = addr_reg;
  assign o_bram_wdata = wdata_reg;
  assign o_a_rvalid   = a_rvalid_reg;
  assign o_b_rvalid   = b_rvalid_reg;
  assign o_a_rdata    = a_rdata_reg;
  assign o_b_rdata    = b_rdata_reg;

endmodule

// File: tb/tb_bram_port_arbiter.sv
`timescale 1ns/1ps
// Bench for bram_port_arbiter: BRAM model, transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bram_port_arbiter;
  localparam int AW     = 12;
  localparam int DW     = 64;
  localparam int RD_LAT = 1;
`ifdef BRAM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, b_req = 1'b0;
  logic          a_gnt, b_gnt;
  logic [7:0]    a_we = '0, b_we = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          bram_en;
  logic [7:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata, bram_rdata;
  logic [31:0]   a_cnt, b_cnt;

  always #5 clk = ~clk;

  bram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .i_clk(clk), .i_rstn(rst_n),
    .i_a_req(a_req), .i_b_req(b_req), .o_a_gnt(a_gnt), .o_b_gnt(b_gnt),
    .i_a_we(a_we), .i_b_we(b_we), .i_a_addr(a_addr), .i_b_addr(b_addr),
    .i_a_wdata(a_wdata), .i_b_wdata(b_wdata),
    .o_a_rvalid(a_rvalid), .o_b_rvalid(b_rvalid), .o_a_rdata(a_rdata), .o_b_rdata(b_rdata),
    .o_bram_en(bram_en), .o_bram_we(bram_we), .o_bram_addr(bram_addr),
    .o_bram_wdata(bram_wdata), .i_bram_rdata(bram_rdata),
    .o_a_cnt(a_cnt), .o_b_cnt(b_cnt)
  );

  // Unwritten words read back a recognisable address-dependent pattern.
  function automatic logic [63:0] pat(input logic [AW-1:0] a);
    return {20'hA5A50, a, 20'h5A5A0, ~a};
  endfunction

  // Single-port BRAM model, read-first, RD_LAT cycles of read latency.
  logic [63:0] bram_mem [0:4095];
  bit          bram_wr [0:4095];
  logic [63:0] rd_pipe [0:1];
  logic [63:0] bram_cur, bram_nxt;
  assign bram_rdata = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (bram_en) begin
      bram_cur = bram_wr[bram_addr] ? bram_mem[bram_addr] : pat(bram_addr);
      bram_nxt = bram_cur;
      for (int i = 0; i < 8; i++)
        if (bram_we[i]) bram_nxt[i*8 +: 8] = bram_wdata[i*8 +: 8];
      if (bram_we != 8'h00) begin
        bram_mem[bram_addr] <= bram_nxt;
        bram_wr[bram_addr]  <= 1'b1;
      end
      rd_pipe[0] <= bram_cur;
    end
    rd_pipe[1] <= rd_pipe[0];
  end

  // Reference model: one entry per accepted read, due RD_LAT+2 cycles after accept.
  typedef struct {
    int          due;
    bit          port;
    logic [63:0] data;
  } rsp_t;
  rsp_t        rsp_q[$];
  logic [63:0] sh_mem [0:4095];
  bit          sh_wr [0:4095];
  bit          m_last_b;
  logic        m_en;
  logic [7:0]  m_we;
  logic [AW-1:0] m_addr;
  logic [63:0] m_wdata, m_rd_a, m_rd_b;
  logic [31:0] m_cnt_a, m_cnt_b;
  bit          acc_a, acc_b;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rsp_q.delete();
    m_last_b = 1'b1;
    m_en = 1'b0; m_we = '0; m_addr = '0; m_wdata = '0;
    m_rd_a = '0; m_rd_b = '0;
    m_cnt_a = '0; m_cnt_b = '0;
  endtask

  // One clock: compare DUT against the model at negedge, advance model, return at posedge+1.
  task automatic step();
    bit ea, eb, va, vb;
    logic [7:0]    we;
    logic [AW-1:0] ad;
    logic [63:0]   wd, cur;
    rsp_t r;
    @(negedge clk);
    acc_a = 1'b0; acc_b = 1'b0;
    if (!rst_n) begin
      model_reset();
      chk("rst_bram_en", bram_en, 0);
      chk("rst_bram_we", bram_we, 0);
      chk("rst_bram_addr", bram_addr, 0);
      chk("rst_bram_wdata", bram_wdata, 0);
      chk("rst_rvalid_a", a_rvalid, 0);
      chk("rst_rvalid_b", b_rvalid, 0);
      chk("rst_rdata_a", a_rdata, 0);
      chk("rst_rdata_b", b_rdata, 0);
      chk("rst_cnt_a", a_cnt, 0);
      chk("rst_cnt_b", b_cnt, 0);
    end else begin
      if (a_req && b_req) begin
        ea = m_last_b; eb = !m_last_b;
      end else begin
        ea = a_req; eb = b_req;
      end
      chk("gnt_a", a_gnt, ea);
      chk("gnt_b", b_gnt, eb);
      chk("bram_en", bram_en, m_en);
      chk("bram_we", bram_we, m_we);
      chk("bram_addr", bram_addr, m_addr);
      chk("bram_wdata", bram_wdata, m_wdata);
      va = 1'b0; vb = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        r = rsp_q.pop_front();
        if (r.port) begin vb = 1'b1; m_rd_b = r.data; end
        else begin va = 1'b1; m_rd_a = r.data; end
      end
      chk("rvalid_a", a_rvalid, va);
      chk("rvalid_b", b_rvalid, vb);
      chk("rdata_a", a_rdata, m_rd_a);
      chk("rdata_b", b_rdata, m_rd_b);
      chk("cnt_a", a_cnt, PERF ? m_cnt_a : 32'd0);
      chk("cnt_b", b_cnt, PERF ? m_cnt_b : 32'd0);

      m_en = ea | eb;
      m_we = '0;
      if (ea || eb) begin
        we = eb ? b_we : a_we;
        ad = eb ? b_addr : a_addr;
        wd = eb ? b_wdata : a_wdata;
        m_we = we; m_addr = ad; m_wdata = wd;
        m_last_b = eb;
        cur = sh_wr[ad] ? sh_mem[ad] : pat(ad);
        if (we == 8'h00) begin
          r.due = cyc + RD_LAT + 2; r.port = eb; r.data = cur;
          rsp_q.push_back(r);
        end else begin
          for (int i = 0; i < 8; i++)
            if (we[i]) cur[i*8 +: 8] = wd[i*8 +: 8];
          sh_mem[ad] = cur;
          sh_wr[ad] = 1'b1;
        end
        if (ea && m_cnt_a != 32'hFFFF_FFFF) m_cnt_a++;
        if (eb && m_cnt_b != 32'hFFFF_FFFF) m_cnt_b++;
        acc_a = ea; acc_b = eb;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0; b_req = 1'b0; a_we = '0; b_we = '0;
  endtask

  task automatic a_cmd(input logic [7:0] we, input logic [AW-1:0] ad, input logic [63:0] wd);
    a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
  endtask

  task automatic b_cmd(input logic [7:0] we, input logic [AW-1:0] ad, input logic [63:0] wd);
    b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd;
  endtask

  initial begin
    model_reset();
    idle();
    repeat (3) step();
    rst_n = 1'b1;

    // Continuous reads from both ports straight out of reset.
    a_cmd(8'h00, 12'h100, '0);
    b_cmd(8'h00, 12'h200, '0);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i < 4) begin
        chk("alt_gnt_a", a_gnt, (i % 2 == 0));
        chk("alt_gnt_b", b_gnt, (i % 2 == 1));
      end
      step();
      if (i == RD_LAT + 1) begin
        chk("alt_first_rvalid_a", a_rvalid, 1);
        chk("alt_first_rdata_a", a_rdata, 64'hA5A50100_5A5A0EFF);
      end
      if (i == RD_LAT + 2) begin
        chk("alt_first_rvalid_b", b_rvalid, 1);
        chk("alt_first_rdata_b", b_rdata, 64'hA5A50200_5A5A0DFF);
      end
      if (acc_a) a_addr = a_addr + 12'd1;
      if (acc_b) b_addr = b_addr + 12'd1;
    end
    idle();
    repeat (RD_LAT + 3) step();

    // Full write then read back on A, exact latency.
    a_cmd(8'hFF, 12'h010, 64'h1122334455667788);
    step();
    a_cmd(8'h00, 12'h010, '0);
    step();
    idle();
    repeat (RD_LAT) step();
    chk("wr_rd_early_rvalid_a", a_rvalid, 0);
    step();
    chk("wr_rd_rvalid_a", a_rvalid, 1);
    chk("wr_rd_rdata_a", a_rdata, 64'h1122334455667788);
    chk("wr_rd_rvalid_b", b_rvalid, 0);
    step();

    // Byte-enable merge.
    a_cmd(8'hFF, 12'h020, 64'h1122334455667788);
    step();
    a_cmd(8'h0F, 12'h020, 64'hAAAAAAAA_BBBBBBBB);
    step();
    a_cmd(8'h00, 12'h020, '0);
    step();
    idle();
    repeat (RD_LAT + 1) step();
    chk("be_rvalid_a", a_rvalid, 1);
    chk("be_rdata_a", a_rdata, 64'h11223344_BBBBBBBB);
    step();

    // B writes, A reads the same word on the next cycle.
    b_cmd(8'hFF, 12'h030, 64'hCAFEF00D_DEADBEEF);
    step();
    idle();
    a_cmd(8'h00, 12'h030, '0);
    step();
    idle();
    repeat (RD_LAT + 1) step();
    chk("raw_rvalid_a", a_rvalid, 1);
    chk("raw_rdata_a", a_rdata, 64'hCAFEF00D_DEADBEEF);
    step();

    // Reset with two reads in flight.
    a_cmd(8'h00, 12'h040, '0);
    step();
    idle();
    b_cmd(8'h00, 12'h050, '0);
    step();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      step();
      chk("post_rst_rvalid_a", a_rvalid, 0);
      chk("post_rst_rvalid_b", b_rvalid, 0);
      chk("post_rst_rdata_a", a_rdata, 0);
      chk("post_rst_rdata_b", b_rdata, 0);
    end

    // Tie after reset goes to A; then build up 5 A grants and 3 B grants.
    a_cmd(8'h00, 12'h060, '0);
    b_cmd(8'h00, 12'h070, '0);
    #1;
    chk("post_rst_tie_gnt_a", a_gnt, 1);
    chk("post_rst_tie_gnt_b", b_gnt, 0);
    step();
    a_req = 1'b0;
    step();
    idle();
    a_cmd(8'h00, 12'h061, '0);
    repeat (4) step();
    idle();
    b_cmd(8'h00, 12'h071, '0);
    repeat (2) step();
    idle();
    chk("cnt_a_five", a_cnt, PERF ? 32'd5 : 32'd0);
    chk("cnt_b_three", b_cnt, PERF ? 32'd3 : 32'd0);

`ifdef BRAM_ARB_PERF_EN
    force dut.a_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.a_cnt_reg;
    m_cnt_a = 32'hFFFF_FFFF;
    a_cmd(8'h00, 12'h062, '0);
    step();
    idle();
    chk("cnt_a_saturated", a_cnt, 32'hFFFF_FFFF);
    chk("cnt_b_unchanged", b_cnt, 32'd3);
`endif

    repeat (RD_LAT + 4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
